bcd_event_counter_ctrl: RTL and testbench
=========================================

BCD_EVENT_COUNTER_CTRL -- requirements
Module: bcd_event_counter_ctrl

Interface
REQ-001 The block SHALL have parameter SATURATE, default 0: 0 = wrap 999->000, 1 = hold at 999.
REQ-002 The block SHALL have parameter PRESCALE, default 1: qualified ticks per increment, legal range 1..15.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  enter RUN.
REQ-007 stop  in  1  enter IDLE (pause; count kept).
REQ-008 clr  in  1  synchronous clear of count, ovf, prescaler; state to IDLE.
REQ-009 load  in  1  synchronous load of load_val into count.
REQ-010 load_val  in  12  three BCD digits [11:8]=hundreds, [7:4]=tens, [3:0]=units.
REQ-011 tick  in  1  count event, one per cycle maximum.
REQ-012 snap_req  in  1  request snapshot of count.
REQ-013 snap_ready  in  1  consumer accepts snapshot.
REQ-014 count  out  12  registered BCD count.
REQ-015 ovf  out  1  sticky overflow flag.
REQ-016 running  out  1  high in RUN.
REQ-017 load_err  out  1  one-cycle pulse on rejected load.
REQ-018 snap_valid  out  1  snapshot available.
REQ-019 snap_data  out  12  snapshot value, stable while snap_valid=1.

Function
REQ-020 The block SHALL contain one instance of the team's 3-digit BCD incrementer (12-bit in, en, 12-bit out, ovf) with in=count; its en SHALL be driven by inc_fire.
REQ-021 The FSM SHALL have states IDLE, RUN and SAT. SAT SHALL be reachable only when SATURATE=1.
REQ-022 Command priority SHALL be clr > load > stop > start, and only the highest asserted command SHALL act in a cycle.
REQ-023 Transitions:
- IDLE->RUN on start.
- RUN->IDLE on stop.
- RUN->SAT on overflow when SATURATE=1.
- Any state->IDLE on clr.
- SAT SHALL ignore start, stop and tick.
REQ-024 In RUN with no command asserted, tick SHALL advance the 4-bit prescaler. When prescaler=PRESCALE-1 and tick=1, inc_fire=1 and the prescaler SHALL return to 0.
REQ-025 On inc_fire, count SHALL be loaded with the incrementer out at the same edge, so the new value is visible one cycle after the tick.
REQ-026 On inc_fire with count=999:
- SATURATE=0: count SHALL become 000 and ovf SHALL be set.
- SATURATE=1: count SHALL stay 999, ovf SHALL be set, and the next state SHALL be SAT.
REQ-027 ovf SHALL clear only on clr or reset.
REQ-028 load SHALL be accepted in IDLE and RUN when every digit of load_val is <=9: count <= load_val, prescaler <= 0, state unchanged, ovf unchanged.
REQ-029 load SHALL be rejected when any digit is >9 or the state is SAT. On rejection, count SHALL be unchanged and load_err SHALL pulse high for the next cycle.
REQ-030 A tick in the same cycle as clr, load or stop SHALL be discarded.
REQ-031 When snap_req=1 and snap_valid=0, snap_data SHALL capture count as registered before that edge, and snap_valid SHALL go 1 the next cycle.
REQ-032 When snap_valid=1 and snap_ready=1, snap_valid SHALL clear. If snap_req is also 1 in that cycle, a new capture SHALL occur and snap_valid SHALL stay 1.
REQ-033 snap_req while snap_valid=1 and snap_ready=0 SHALL be ignored, with snap_data held.
REQ-034 clr SHALL NOT affect the snapshot path.

Reset
REQ-035 reset_n=0 SHALL immediately force:
- state to IDLE;
- count, prescaler and snap_data to 000;
- ovf, running, load_err and snap_valid to 0.
REQ-036 Deassertion of reset_n SHALL be synchronised so the first active edge follows two clk edges after release; reset mid-count SHALL discard all progress.

Verification
REQ-037 Wrap: SATURATE=0, PRESCALE=1, load 998, start, 2 ticks -> count 999, then 000 with ovf=1, running=1.
REQ-038 Saturate: SATURATE=1, load 999, start, tick -> count 999, ovf=1, running=0, state SAT; further ticks and start -> no change; clr -> 000, ovf=0, IDLE.
REQ-039 Prescale and digit carry: PRESCALE=3, load 099, start, 3 ticks -> count 100 one cycle after the third tick; 2 ticks -> count still 100.
REQ-040 Load check: load_val=12'h1A3 -> load_err pulse, count unchanged; load_val=12'h123 in SAT -> rejected; in RUN -> count 123, running=1.
REQ-041 Snapshot handshake: count=456, snap_req with snap_ready=0 -> snap_valid=1, snap_data=456; count advances to 460 and a second snap_req -> data stays 456; snap_ready=1 with snap_req -> snap_data=460, snap_valid stays 1.
REQ-042 Priority: clr, load, stop and tick together -> count 000, IDLE, no load_err; reset_n pulse mid-RUN -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/bcd_event_counter_ctrl.sv
// Three-digit BCD event counter with prescaler, wrap/saturate overflow policy,
// checked loads and a ready/valid snapshot port.

// 3-digit BCD incrementer: out = in + 1 (BCD) when en, ovf flags the 999 -> 000 rollover.
module bcd_inc3 (
    input  logic [11:0] in,
    input  logic        en,
    output logic [11:0] out,
    output logic        ovf
);
    logic carry_tens;
    logic carry_hund;

    function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic c);
        if (!c) begin
            return d;
        end
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    assign carry_tens = en && (in[3:0] == 4'd9);
    assign carry_hund = carry_tens && (in[7:4] == 4'd9);
    assign ovf        = carry_hund && (in[11:8] == 4'd9);

    assign out = {digit_inc(in[11:8], carry_hund),
                  digit_inc(in[7:4], carry_tens),
                  digit_inc(in[3:0], en)};
endmodule

module bcd_event_counter_ctrl #(
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic        clr,
    input  logic        load,
    input  logic [11:0] load_val,
    input  logic        tick,
    input  logic        snap_req,
    input  logic        snap_ready,
    output logic [11:0] count,
    output logic        ovf,
    output logic        running,
    output logic        load_err,
    output logic        snap_valid,
    output logic [11:0] snap_data
);
    typedef enum logic [1:0] {StIdle, StRun, StSat} state_e;

    localparam logic [3:0] PscLast = 4'(PRESCALE - 1);

    state_e      state_q, state_d;
    logic [11:0] count_q, count_d;
    logic [3:0]  psc_q, psc_d;
    logic        ovf_q, ovf_d;
    logic        load_err_q, load_err_d;
    logic        snap_valid_q, snap_valid_d;
    logic [11:0] snap_data_q, snap_data_d;
    logic [1:0]  rst_sync_q;
    logic        rst_int_n;
    logic        inc_fire;
    logic        load_ok;
    logic [11:0] inc_out;
    logic        inc_ovf;

    // Assert asynchronously, release only after two clock edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

    assign load_ok = (load_val[11:8] <= 4'd9) && (load_val[7:4] <= 4'd9)
                     && (load_val[3:0] <= 4'd9) && (state_q != StSat);

    assign inc_fire = !clr && !load && !stop && !start && tick
                      && (state_q == StRun) && (psc_q == PscLast);

    bcd_inc3 u_inc (
        .in  (count_q),
        .en  (inc_fire),
        .out (inc_out),
        .ovf (inc_ovf)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        psc_d      = psc_q;
        ovf_d      = ovf_q;
        load_err_d = 1'b0;
        if (clr) begin
            state_d = StIdle;
            count_d = 12'h000;
            psc_d   = 4'd0;
            ovf_d   = 1'b0;
        end else if (load) begin
            if (load_ok) begin
                count_d = load_val;
                psc_d   = 4'd0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (stop) begin
            if (state_q == StRun) begin
                state_d = StIdle;
            end
        end else if (start) begin
            if (state_q == StIdle) begin
                state_d = StRun;
            end
        end else if (inc_fire) begin
            psc_d   = 4'd0;
            count_d = inc_out;
            if (inc_ovf) begin
                ovf_d = 1'b1;
                if (SATURATE) begin
                    count_d = count_q;
                    state_d = StSat;
                end
            end
        end else if (state_q == StRun && tick) begin
            psc_d = psc_q + 4'd1;
        end
    end

    // Snapshot path is deliberately independent of clr.
    always_comb begin
        snap_valid_d = snap_valid_q;
        snap_data_d  = snap_data_q;
        if (snap_valid_q && snap_ready) begin
            snap_valid_d = snap_req;
            if (snap_req) begin
                snap_data_d = count_q;
            end
        end else if (!snap_valid_q && snap_req) begin
            snap_valid_d = 1'b1;
            snap_data_d  = count_q;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q      <= StIdle;
            count_q      <= 12'h000;
            psc_q        <= 4'd0;
            ovf_q        <= 1'b0;
            load_err_q   <= 1'b0;
            snap_valid_q <= 1'b0;
            snap_data_q  <= 12'h000;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            psc_q        <= psc_d;
            ovf_q        <= ovf_d;
            load_err_q   <= load_err_d;
            snap_valid_q <= snap_valid_d;
            snap_data_q  <= snap_data_d;
        end
    end

    assign count      = count_q;
    assign ovf        = ovf_q;
    assign running    = (state_q == StRun);
    assign load_err   = load_err_q;
    assign snap_valid = snap_valid_q;
    assign snap_data  = snap_data_q;
endmodule

// File: tb/tb_bcd_event_counter_ctrl.sv
// Bench: three counter variants (wrap/P1, saturate/P1, wrap/P3) driven in lockstep
// and compared every cycle against an integer-arithmetic reference model.
module tb_bcd_event_counter_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, clr = 1'b0, load = 1'b0, tick = 1'b0;
    logic        snap_req = 1'b0, snap_ready = 1'b0;
    logic [11:0] load_val = 12'h000;

    logic [11:0] count [3];
    logic [11:0] snap_data [3];
    logic        ovf [3], running [3], load_err [3], snap_valid [3];

    int total = 0;
    int bad   = 0;

    int          m_cnt [3];
    int          m_psc [3];
    bit          m_ovf [3], m_run [3], m_sat [3], m_lerr [3], m_sv [3];
    logic [11:0] m_sd [3];
    int          m_hold = 2;

    always #5 clk = ~clk;

    bcd_event_counter_ctrl #(.SATURATE(1'b0), .PRESCALE(1)) u_wrap (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clr(clr), .load(load),
        .load_val(load_val), .tick(tick), .snap_req(snap_req), .snap_ready(snap_ready),
        .count(count[0]), .ovf(ovf[0]), .running(running[0]), .load_err(load_err[0]),
        .snap_valid(snap_valid[0]), .snap_data(snap_data[0])
    );

    bcd_event_counter_ctrl #(.SATURATE(1'b1), .PRESCALE(1)) u_sat (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clr(clr), .load(load),
        .load_val(load_val), .tick(tick), .snap_req(snap_req), .snap_ready(snap_ready),
        .count(count[1]), .ovf(ovf[1]), .running(running[1]), .load_err(load_err[1]),
        .snap_valid(snap_valid[1]), .snap_data(snap_data[1])
    );

    bcd_event_counter_ctrl #(.SATURATE(1'b0), .PRESCALE(3)) u_psc3 (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clr(clr), .load(load),
        .load_val(load_val), .tick(tick), .snap_req(snap_req), .snap_ready(snap_ready),
        .count(count[2]), .ovf(ovf[2]), .running(running[2]), .load_err(load_err[2]),
        .snap_valid(snap_valid[2]), .snap_data(snap_data[2])
    );

    function automatic bit sat_of(input int i);
        return i == 1;
    endfunction

    function automatic int pre_of(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    function automatic logic [11:0] int2bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int bcd2int(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit digits_ok(input logic [11:0] b);
        return (b[11:8] <= 4'd9) && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_psc[i] = 0; m_ovf[i] = 0; m_run[i] = 0; m_sat[i] = 0;
            m_lerr[i] = 0; m_sv[i] = 0; m_sd[i] = 12'h000;
        end
    endtask

    task automatic model_step();
        if (m_hold > 0) begin
            m_hold--;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            m_lerr[i] = 0;
            if (m_sv[i] && snap_ready) begin
                if (snap_req) m_sd[i] = int2bcd(m_cnt[i]);
                else m_sv[i] = 0;
            end else if (!m_sv[i] && snap_req) begin
                m_sd[i] = int2bcd(m_cnt[i]);
                m_sv[i] = 1;
            end
            if (clr) begin
                m_cnt[i] = 0; m_psc[i] = 0; m_ovf[i] = 0; m_run[i] = 0; m_sat[i] = 0;
            end else if (load) begin
                if (!m_sat[i] && digits_ok(load_val)) begin
                    m_cnt[i] = bcd2int(load_val);
                    m_psc[i] = 0;
                end else begin
                    m_lerr[i] = 1;
                end
            end else if (stop) begin
                m_run[i] = 0;
            end else if (start) begin
                if (!m_sat[i]) m_run[i] = 1;
            end else if (m_run[i] && tick) begin
                m_psc[i]++;
                if (m_psc[i] == pre_of(i)) begin
                    m_psc[i] = 0;
                    if (m_cnt[i] == 999) begin
                        m_ovf[i] = 1;
                        if (sat_of(i)) begin
                            m_run[i] = 0;
                            m_sat[i] = 1;
                        end else begin
                            m_cnt[i] = 0;
                        end
                    end else begin
                        m_cnt[i]++;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("u%0d.count", i), count[i], int2bcd(m_cnt[i]));
            check_eq($sformatf("u%0d.ovf", i), 12'(ovf[i]), 12'(m_ovf[i]));
            check_eq($sformatf("u%0d.running", i), 12'(running[i]), 12'(m_run[i]));
            check_eq($sformatf("u%0d.load_err", i), 12'(load_err[i]), 12'(m_lerr[i]));
            check_eq($sformatf("u%0d.snap_valid", i), 12'(snap_valid[i]), 12'(m_sv[i]));
            check_eq($sformatf("u%0d.snap_data", i), snap_data[i], m_sd[i]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic step_cmd(input bit c, input bit l, input logic [11:0] lv,
                            input bit sp, input bit st, input bit tk);
        clr = c; load = l; load_val = lv; stop = sp; start = st; tick = tk;
        cycle();
        clr = 0; load = 0; stop = 0; start = 0; tick = 0;
    endtask

    // Called just after a checked edge; asserts reset mid-cycle, releases on negedge.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        m_hold = 2;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        check_all();
        reset_n = 1'b1;

        // start held across the synchroniser release: only the third edge acts
        start = 1;
        repeat (3) cycle();
        start = 0;
        check_eq("sync_release_running", 12'(running[0]), 12'h001);
        step_cmd(1, 0, 12'h000, 0, 0, 0);

        // wrap and saturate at 999
        step_cmd(0, 1, 12'h998, 0, 0, 0);
        step_cmd(0, 0, 12'h000, 0, 1, 0);
        step_cmd(0, 0, 12'h000, 0, 0, 1);
        check_eq("wrap_999", count[0], 12'h999);
        step_cmd(0, 0, 12'h000, 0, 0, 1);
        check_eq("wrap_000", count[0], 12'h000);
        check_eq("wrap_ovf", 12'(ovf[0]), 12'h001);
        check_eq("wrap_running", 12'(running[0]), 12'h001);
        check_eq("sat_hold", count[1], 12'h999);
        check_eq("sat_running", 12'(running[1]), 12'h000);
        step_cmd(0, 0, 12'h000, 0, 0, 1);
        step_cmd(0, 0, 12'h000, 0, 1, 0);
        check_eq("sat_ignores_start", 12'(running[1]), 12'h000);
        check_eq("sat_ignores_tick", count[1], 12'h999);
        step_cmd(1, 0, 12'h000, 0, 0, 0);
        check_eq("sat_clr_count", count[1], 12'h000);
        check_eq("sat_clr_ovf", 12'(ovf[1]), 12'h000);

        // prescale 3 with digit carry
        step_cmd(0, 1, 12'h099, 0, 0, 0);
        step_cmd(0, 0, 12'h000, 0, 1, 0);
        repeat (3) step_cmd(0, 0, 12'h000, 0, 0, 1);
        check_eq("psc3_carry", count[2], 12'h100);
        repeat (2) step_cmd(0, 0, 12'h000, 0, 0, 1);
        check_eq("psc3_hold", count[2], 12'h100);

        // load validation
        step_cmd(0, 1, 12'h1A3, 0, 0, 0);
        check_eq("bad_digit_err", 12'(load_err[0]), 12'h001);
        check_eq("bad_digit_count", count[0], 12'h104);
        step_cmd(0, 1, 12'h999, 0, 0, 0);
        step_cmd(0, 0, 12'h000, 0, 0, 1);
        step_cmd(0, 1, 12'h123, 0, 0, 0);
        check_eq("sat_load_err", 12'(load_err[1]), 12'h001);
        check_eq("sat_load_count", count[1], 12'h999);
        check_eq("run_load_count", count[0], 12'h123);
        check_eq("run_load_running", 12'(running[0]), 12'h001);

        // snapshot handshake
        step_cmd(1, 0, 12'h000, 0, 0, 0);
        step_cmd(0, 1, 12'h456, 0, 0, 0);
        step_cmd(0, 0, 12'h000, 0, 1, 0);
        snap_req = 1; snap_ready = 0;
        cycle();
        snap_req = 0;
        check_eq("snap_first", snap_data[0], 12'h456);
        repeat (4) step_cmd(0, 0, 12'h000, 0, 0, 1);
        snap_req = 1;
        cycle();
        check_eq("snap_held", snap_data[0], 12'h456);
        snap_ready = 1;
        cycle();
        check_eq("snap_recapture", snap_data[0], 12'h460);
        check_eq("snap_valid_kept", 12'(snap_valid[0]), 12'h001);
        snap_req = 0;
        cycle();
        snap_ready = 0;

        // all commands together, then an asynchronous reset mid-run
        step_cmd(1, 1, 12'h123, 1, 1, 1);
        check_eq("prio_count", count[0], 12'h000);
        check_eq("prio_load_err", 12'(load_err[0]), 12'h000);
        step_cmd(0, 0, 12'h000, 0, 1, 0);
        repeat (3) step_cmd(0, 0, 12'h000, 0, 0, 1);
        do_reset();

        for (int n = 0; n < 3000; n++) begin
            clr        = ($urandom_range(0, 49) == 0);
            load       = ($urandom_range(0, 11) == 0);
            stop       = ($urandom_range(0, 14) == 0);
            start      = ($urandom_range(0, 5) == 0);
            tick       = ($urandom_range(0, 3) != 0);
            snap_req   = ($urandom_range(0, 3) == 0);
            snap_ready = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 2))
                0: load_val = 12'($urandom);
                1: load_val = int2bcd($urandom_range(990, 999));
                default: load_val = int2bcd($urandom_range(0, 999));
            endcase
            cycle();
            if ($urandom_range(0, 799) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
